// File: rtl/grid_snapshot_csr_pkg.sv
// grid_if_pkg: shared constants for the grid snapshot CSR block.
//   Register offsets are relative to ROWS (the first word after the row
//   window), plus CTRL bit positions and the change-sequence counter width.
package grid_if_pkg;
    localparam int OFS_STATUS  = 0;
    localparam int OFS_CTRL    = 1;
    localparam int OFS_DIRTY   = 2;

    localparam int CTRL_FREEZE = 0;
    localparam int CTRL_IRQ_EN = 1;
    localparam int CTRL_SNAP   = 2;

    localparam int SEQ_W       = 16;
endpackage

// File: rtl/grid_snapshot_csr_dirty_tracker.sv
// grid_dirty_tracker: per-row dirty flags and change sequence counter.
//   clk, reset   : clock, synchronous active-high reset
//   i_capture    : shadow is being reloaded from the live grid this edge
//   i_grid       : live grid (ROWS*COLS packed, row r at [r*COLS +: COLS])
//   i_shadow     : current shadow copy (pre-edge)
//   i_clear      : write-1-to-clear mask for the dirty flags
//   o_dirty      : per-row dirty flags
//   o_seq        : count of captures that changed at least one row
module grid_dirty_tracker
    import grid_if_pkg::*;
#(
    parameter int COLS = 10,
    parameter int ROWS = 20
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_capture,
    input  logic [ROWS*COLS-1:0]   i_grid,
    input  logic [ROWS*COLS-1:0]   i_shadow,
    input  logic [ROWS-1:0]        i_clear,
    output logic [ROWS-1:0]        o_dirty,
    output logic [SEQ_W-1:0]       o_seq
);
    logic [ROWS-1:0]  w_diff;
    logic [ROWS-1:0]  r_dirty;
    logic [SEQ_W-1:0] r_seq;

    always_comb begin
        w_diff = '0;
        for (int r = 0; r < ROWS; r++)
            w_diff[r] = (i_grid[r*COLS +: COLS] != i_shadow[r*COLS +: COLS]);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_dirty <= '0;
            r_seq   <= '0;
        end else begin
            // Set is OR-ed in after the clear so a same-cycle change survives.
            r_dirty <= (r_dirty & ~i_clear) | (i_capture ? w_diff : '0);
            if (i_capture && (|w_diff))
                r_seq <= r_seq + 1'b1;
        end
    end

    assign o_dirty = r_dirty;
    assign o_seq   = r_seq;
endmodule

// File: rtl/grid_snapshot_csr.sv
// grid_snapshot_csr: Avalon-MM slave giving the CPU a coherent view of the
// game grid via a shadow copy that is live-tracking or frozen.
//   clk, reset          : clock, synchronous active-high reset
//   grid_state          : live grid from the game core
//   avs_address         : word address (rows, STATUS, CTRL, DIRTY)
//   avs_read/avs_write  : bus strobes, no waitrequest
//   avs_writedata       : write data
//   avs_readdata        : read data, fixed latency 1, held between reads
//   avs_readdatavalid   : one-cycle pulse per read
//   irq                 : level interrupt, IRQ_EN & any dirty row (registered)
module grid_snapshot_csr
    import grid_if_pkg::*;
#(
    parameter int COLS   = 10,
    parameter int ROWS   = 20,
    parameter int ADDR_W = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [ROWS*COLS-1:0] grid_state,
    input  logic [ADDR_W-1:0]    avs_address,
    input  logic                 avs_read,
    input  logic                 avs_write,
    input  logic [31:0]          avs_writedata,
    output logic [31:0]          avs_readdata,
    output logic                 avs_readdatavalid,
    output logic                 irq
);
    if (COLS > 32 || ROWS > 32 || (2**ADDR_W) < ROWS + 3) begin : g_bad_param
        $error("grid_snapshot_csr: illegal COLS/ROWS/ADDR_W combination");
    end

    localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(ROWS + OFS_STATUS);
    localparam logic [ADDR_W-1:0] A_CTRL   = ADDR_W'(ROWS + OFS_CTRL);
    localparam logic [ADDR_W-1:0] A_DIRTY  = ADDR_W'(ROWS + OFS_DIRTY);

    logic [ROWS*COLS-1:0] r_shadow;
    logic                 r_freeze;
    logic                 r_irq_en;
    logic [31:0]          r_rdata;
    logic                 r_rvalid;
    logic                 r_irq;

    logic                 w_ctrl_wr;
    logic                 w_capture;
    logic [ROWS-1:0]      w_clear;
    logic [ROWS-1:0]      w_dirty;
    logic [SEQ_W-1:0]     w_seq;
    logic                 w_any_dirty;
    logic [31:0]          w_rdata;
    logic                 w_unused;

    assign w_ctrl_wr   = avs_write && (avs_address == A_CTRL);
    // SNAP forces a capture on the edge that accepts the write, even while
    // frozen; the FREEZE bit written alongside only takes effect afterwards.
    assign w_capture   = !r_freeze || (w_ctrl_wr && avs_writedata[CTRL_SNAP]);
    assign w_clear     = (avs_write && (avs_address == A_DIRTY)) ?
                         avs_writedata[ROWS-1:0] : '0;
    assign w_any_dirty = |w_dirty;
    assign w_unused    = ^avs_writedata;

    grid_dirty_tracker #(.COLS(COLS), .ROWS(ROWS)) u_tracker (
        .clk       (clk),
        .reset     (reset),
        .i_capture (w_capture),
        .i_grid    (grid_state),
        .i_shadow  (r_shadow),
        .i_clear   (w_clear),
        .o_dirty   (w_dirty),
        .o_seq     (w_seq)
    );

    // Read mux works on pre-edge state, so a read racing a write or a
    // capture returns the old contents.
    always_comb begin
        w_rdata = '0;
        for (int r = 0; r < ROWS; r++)
            if (avs_address == ADDR_W'(r))
                w_rdata = 32'(r_shadow[r*COLS +: COLS]);
        if (avs_address == A_STATUS)
            w_rdata = {w_seq, 15'b0, w_any_dirty};
        else if (avs_address == A_CTRL)
            w_rdata = {30'b0, r_irq_en, r_freeze};
        else if (avs_address == A_DIRTY)
            w_rdata = 32'(w_dirty);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_shadow <= '0;
            r_freeze <= 1'b0;
            r_irq_en <= 1'b0;
            r_rdata  <= '0;
            r_rvalid <= 1'b0;
            r_irq    <= 1'b0;
        end else begin
            if (w_capture)
                r_shadow <= grid_state;
            if (w_ctrl_wr) begin
                r_freeze <= avs_writedata[CTRL_FREEZE];
                r_irq_en <= avs_writedata[CTRL_IRQ_EN];
            end
            r_rvalid <= avs_read;
            if (avs_read)
                r_rdata <= w_rdata;
            r_irq <= r_irq_en & w_any_dirty;
        end
    end

    assign avs_readdata      = r_rdata;
    assign avs_readdatavalid = r_rvalid;
    assign irq               = r_irq;
endmodule

// File: tb/tb_grid_snapshot_csr.sv
module tb_grid_snapshot_csr;
    localparam int COLS   = 10;
    localparam int ROWS   = 20;
    localparam int ADDR_W = 5;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [ROWS*COLS-1:0] grid_state;
    logic [ADDR_W-1:0]    avs_address;
    logic                 avs_read;
    logic                 avs_write;
    logic [31:0]          avs_writedata;
    logic [31:0]          avs_readdata;
    logic                 avs_readdatavalid;
    logic                 irq;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    grid_snapshot_csr #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(ADDR_W)) dut (
        .clk               (clk),
        .reset             (reset),
        .grid_state        (grid_state),
        .avs_address       (avs_address),
        .avs_read          (avs_read),
        .avs_write         (avs_write),
        .avs_writedata     (avs_writedata),
        .avs_readdata      (avs_readdata),
        .avs_readdatavalid (avs_readdatavalid),
        .irq               (irq)
    );

    // Advance one edge and settle past it before anyone samples.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_read(input logic [ADDR_W-1:0] a, output logic [31:0] d, output logic v);
        avs_address = a;
        avs_read    = 1'b1;
        tick();
        avs_read    = 1'b0;
        d = avs_readdata;
        v = avs_readdatavalid;
    endtask

    task automatic do_write(input logic [ADDR_W-1:0] a, input logic [31:0] wd);
        avs_address   = a;
        avs_writedata = wd;
        avs_write     = 1'b1;
        tick();
        avs_write     = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic        v;
        logic [ADDR_W-1:0] addrs [4];
        addrs[0] = 5'd0; addrs[1] = 5'd20; addrs[2] = 5'd21; addrs[3] = 5'd22;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        total++;
        if (irq !== 1'b0 || avs_readdatavalid !== 1'b0 || avs_readdata !== 32'h0) begin
            bad++;
            $display("FAIL reset_outputs irq=%b valid=%b data=%h want 0/0/0", irq, avs_readdatavalid, avs_readdata);
        end
        for (int i = 0; i < 4; i++) begin
            do_read(addrs[i], d, v);
            total++;
            if (v !== 1'b1 || d !== 32'h0) begin
                bad++;
                $display("FAIL reset_read a=%0d data=%h valid=%b want 0/1", addrs[i], d, v);
            end
        end
        tick();
        total++;
        if (avs_readdatavalid !== 1'b0) begin
            bad++;
            $display("FAIL valid_pulse got=%b want 0", avs_readdatavalid);
        end
    endtask

    task automatic test_live();
        logic [31:0] d;
        logic        v;
        grid_state[3*COLS +: COLS] = 10'h2A5;
        tick();
        do_read(5'd3, d, v);
        total++;
        if (d !== 32'h2A5 || v !== 1'b1) begin
            bad++; $display("FAIL live_row3 got=%h want 000002a5", d);
        end
        do_read(5'd22, d, v);
        total++;
        if (d !== 32'h8) begin bad++; $display("FAIL live_dirty got=%h want 00000008", d); end
        do_read(5'd20, d, v);
        total++;
        if (d !== 32'h00010001) begin bad++; $display("FAIL live_status got=%h want 00010001", d); end
    endtask

    task automatic test_freeze_snap();
        logic [31:0] d;
        logic        v;
        do_write(5'd21, 32'h1);
        grid_state[0 +: COLS] = 10'h3FF;
        tick();
        tick();
        do_read(5'd0, d, v);
        total++;
        if (d !== 32'h0) begin bad++; $display("FAIL frozen_row0 got=%h want 00000000", d); end
        do_read(5'd20, d, v);
        total++;
        if (d !== 32'h00010001) begin bad++; $display("FAIL frozen_status got=%h want 00010001", d); end
        do_write(5'd21, 32'h5);
        do_read(5'd0, d, v);
        total++;
        if (d !== 32'h3FF) begin bad++; $display("FAIL snap_row0 got=%h want 000003ff", d); end
        do_read(5'd20, d, v);
        total++;
        if (d !== 32'h00020001) begin bad++; $display("FAIL snap_status got=%h want 00020001", d); end
        do_read(5'd21, d, v);
        total++;
        if (d !== 32'h1) begin bad++; $display("FAIL snap_ctrl got=%h want 00000001", d); end
        do_read(5'd22, d, v);
        total++;
        if (d !== 32'h9) begin bad++; $display("FAIL snap_dirty got=%h want 00000009", d); end
        do_write(5'd22, 32'h1);
        do_read(5'd22, d, v);
        total++;
        if (d !== 32'h8) begin bad++; $display("FAIL w1c_bit0 got=%h want 00000008", d); end
    endtask

    task automatic test_irq();
        logic [31:0] d;
        logic        v;
        do_write(5'd21, 32'h2);
        total++;
        if (irq !== 1'b0) begin bad++; $display("FAIL irq_early got=%b want 0", irq); end
        tick();
        total++;
        if (irq !== 1'b1) begin bad++; $display("FAIL irq_rise got=%b want 1", irq); end
        do_write(5'd22, 32'h8);
        total++;
        if (irq !== 1'b1) begin bad++; $display("FAIL irq_hold got=%b want 1", irq); end
        tick();
        total++;
        if (irq !== 1'b0) begin bad++; $display("FAIL irq_fall got=%b want 0", irq); end
        do_read(5'd22, d, v);
        total++;
        if (d !== 32'h0) begin bad++; $display("FAIL irq_dirty got=%h want 00000000", d); end
    endtask

    task automatic test_w1c_set_wins();
        logic [31:0] d;
        logic        v;
        grid_state[5*COLS +: COLS] = 10'h155;
        do_write(5'd22, 32'h20);
        do_read(5'd22, d, v);
        total++;
        if (d !== 32'h20) begin bad++; $display("FAIL set_wins got=%h want 00000020", d); end
        do_read(5'd20, d, v);
        total++;
        if (d !== 32'h00030001) begin bad++; $display("FAIL set_wins_status got=%h want 00030001", d); end
        do_write(5'd22, 32'h20);
        do_read(5'd20, d, v);
        total++;
        if (d !== 32'h00030000) begin bad++; $display("FAIL clear_status got=%h want 00030000", d); end
    endtask

    task automatic test_back_to_back();
        avs_read    = 1'b1;
        avs_address = 5'd3;
        tick();
        total++;
        if (avs_readdatavalid !== 1'b1 || avs_readdata !== 32'h2A5) begin
            bad++; $display("FAIL b2b_first valid=%b data=%h want 1/000002a5", avs_readdatavalid, avs_readdata);
        end
        avs_address = 5'd5;
        tick();
        avs_read = 1'b0;
        total++;
        if (avs_readdatavalid !== 1'b1 || avs_readdata !== 32'h155) begin
            bad++; $display("FAIL b2b_second valid=%b data=%h want 1/00000155", avs_readdatavalid, avs_readdata);
        end
        tick();
        total++;
        if (avs_readdatavalid !== 1'b0 || avs_readdata !== 32'h155) begin
            bad++; $display("FAIL b2b_hold valid=%b data=%h want 0/00000155", avs_readdatavalid, avs_readdata);
        end
    endtask

    task automatic test_unmapped_and_rw();
        logic [31:0] d;
        logic        v;
        do_write(5'd25, 32'hFFFF_FFFF);
        do_read(5'd25, d, v);
        total++;
        if (d !== 32'h0 || v !== 1'b1) begin bad++; $display("FAIL unmapped got=%h valid=%b want 0/1", d, v); end
        // Same-cycle read and write of CTRL returns the old value.
        avs_address   = 5'd21;
        avs_writedata = 32'h3;
        avs_write     = 1'b1;
        avs_read      = 1'b1;
        tick();
        avs_write = 1'b0;
        avs_read  = 1'b0;
        total++;
        if (avs_readdata !== 32'h2) begin bad++; $display("FAIL rw_same got=%h want 00000002", avs_readdata); end
        do_read(5'd21, d, v);
        total++;
        if (d !== 32'h3) begin bad++; $display("FAIL rw_after got=%h want 00000003", d); end
    endtask

    task automatic test_reset_pending();
        logic [31:0] d;
        logic        v;
        logic [ADDR_W-1:0] addrs [4];
        addrs[0] = 5'd3; addrs[1] = 5'd20; addrs[2] = 5'd21; addrs[3] = 5'd22;
        grid_state[5*COLS +: COLS] = 10'h0AA;
        tick();
        grid_state    = '0;
        avs_address   = 5'd3;
        avs_read      = 1'b1;
        avs_write     = 1'b1;
        avs_writedata = 32'h3;
        avs_address   = 5'd21;
        reset         = 1'b1;
        tick();
        reset     = 1'b0;
        avs_read  = 1'b0;
        avs_write = 1'b0;
        total++;
        if (avs_readdatavalid !== 1'b0 || irq !== 1'b0 || avs_readdata !== 32'h0) begin
            bad++; $display("FAIL reset_pending valid=%b irq=%b data=%h want 0/0/0", avs_readdatavalid, irq, avs_readdata);
        end
        for (int i = 0; i < 4; i++) begin
            do_read(addrs[i], d, v);
            total++;
            if (d !== 32'h0 || v !== 1'b1) begin
                bad++; $display("FAIL post_reset a=%0d got=%h valid=%b want 0/1", addrs[i], d, v);
            end
        end
    endtask

    initial begin
        reset         = 1'b1;
        grid_state    = '0;
        avs_address   = '0;
        avs_read      = 1'b0;
        avs_write     = 1'b0;
        avs_writedata = '0;
        test_reset();
        test_live();
        test_freeze_snap();
        test_irq();
        test_w1c_set_wins();
        test_back_to_back();
        test_unmapped_and_rw();
        test_reset_pending();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
